alu_cmd_issuer: RTL and testbench

- Command-issue stage directly upstream of the 16-bit registered ALU.
- Buffers operation requests (A, B, function code, tag) in a small FIFO under a valid/ready handshake and drives the ALU's A, B and ALU_FUN inputs from registers, one op per cycle.
- Tracks the ALU's one-cycle register latency so every issued op returns a tag-aligned RES_VALID pulse.
- Screens divide-by-zero: such ops are replaced by a no-op and reported as errors.

---
 rtl/alu_cmd_issuer_if.sv | 36 +++
 rtl/alu_cmd_issuer.sv | 124 ++++++++++++
 tb/tb_alu_cmd_issuer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_cmd_issuer_if.sv
// Command-side and ALU-side signal bundle for alu_cmd_issuer.
// slave = the issuer itself, master = the command source / result sink.
interface alu_cmd_issuer_if #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic             CMD_VALID;
    logic             CMD_READY;
    logic [15:0]      CMD_A;
    logic [15:0]      CMD_B;
    logic [3:0]       CMD_FUN;
    logic [TAG_W-1:0] CMD_TAG;
    logic             HALT;
    logic [15:0]      ALU_A;
    logic [15:0]      ALU_B;
    logic [3:0]       ALU_FUN;
    logic             RES_VALID;
    logic [TAG_W-1:0] RES_TAG;
    logic             RES_DIVZ;
    logic [LVL_W-1:0] CMD_LEVEL;
    logic             BUSY;

    modport slave (
        input  CMD_VALID, CMD_A, CMD_B, CMD_FUN, CMD_TAG, HALT,
        output CMD_READY, ALU_A, ALU_B, ALU_FUN, RES_VALID, RES_TAG, RES_DIVZ,
               CMD_LEVEL, BUSY
    );

    modport master (
        output CMD_VALID, CMD_A, CMD_B, CMD_FUN, CMD_TAG, HALT,
        input  CMD_READY, ALU_A, ALU_B, ALU_FUN, RES_VALID, RES_TAG, RES_DIVZ,
               CMD_LEVEL, BUSY
    );
endinterface

// File: rtl/alu_cmd_issuer.sv
// Queues ALU ops and issues one per cycle into the registered ALU; result tag is 2 edges after issue-free acceptance.
// Accept stalls only when the queue is full; results have no backpressure.
module alu_cmd_issuer #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input logic               CLK,
    input logic               RST,
    alu_cmd_issuer_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam logic [3:0] FUN_NOP = 4'b1111;
    localparam logic [3:0] FUN_DIV = 4'b0011;

    typedef struct packed {
        logic [15:0]      a;
        logic [15:0]      b;
        logic [3:0]       fun;
        logic [TAG_W-1:0] tag;
    } op_t;

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

    op_t              mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [LVL_W-1:0] level;
    logic             full, push, pop, head_dz;
    op_t              head;
    state_t           state, state_nxt;
    logic             iss_v, iss_dz;
    logic [TAG_W-1:0] iss_tag;

    assign full          = (level == LVL_W'(DEPTH));
    assign bus.CMD_READY = !full && !RST;
    assign push          = bus.CMD_VALID && bus.CMD_READY;
    assign head          = mem[rd_ptr];
    assign head_dz       = (head.fun == FUN_DIV) && (head.b == 16'd0);

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: if (push) state_nxt = ISSUE;
            ISSUE: begin
                if (bus.HALT) begin
                    state_nxt = HOLD;
                end else if (level != '0) begin
                    pop = 1'b1;
                    if (level == LVL_W'(1) && !push) state_nxt = IDLE;
                end else if (!push) begin
                    state_nxt = IDLE;
                end
            end
            // A push landing on the release edge still counts as work pending.
            HOLD: if (!bus.HALT) state_nxt = (level != '0 || push) ? ISSUE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= '{a: bus.CMD_A, b: bus.CMD_B, fun: bus.CMD_FUN, tag: bus.CMD_TAG};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            bus.ALU_A   <= '0;
            bus.ALU_B   <= '0;
            bus.ALU_FUN <= FUN_NOP;
            iss_v       <= 1'b0;
            iss_tag     <= '0;
            iss_dz      <= 1'b0;
        end else if (pop) begin
            // Divide-by-zero is swapped for a NOP so the ALU yields 0 with flags low.
            bus.ALU_A   <= head_dz ? 16'd0 : head.a;
            bus.ALU_B   <= head_dz ? 16'd0 : head.b;
            bus.ALU_FUN <= head_dz ? FUN_NOP : head.fun;
            iss_v       <= 1'b1;
            iss_tag     <= head.tag;
            iss_dz      <= head_dz;
        end else begin
            bus.ALU_FUN <= FUN_NOP;
            iss_v       <= 1'b0;
            iss_dz      <= 1'b0;
        end
    end

    // One stage of delay matching the ALU's own output register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            bus.RES_VALID <= 1'b0;
            bus.RES_TAG   <= '0;
            bus.RES_DIVZ  <= 1'b0;
        end else begin
            bus.RES_VALID <= iss_v;
            bus.RES_TAG   <= iss_tag;
            bus.RES_DIVZ  <= iss_dz;
        end
    end

    assign bus.CMD_LEVEL = level;
    assign bus.BUSY      = (level != '0) || iss_v || bus.RES_VALID;
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer with a small registered-ALU model downstream.
module tb_alu_cmd_issuer;
    logic clk;
    logic rst;
    logic [15:0] alu_out;
    int vectors;
    int miscompares;
    int res_tag_q[$];
    int res_out_q[$];
    int res_cyc_q[$];

    alu_cmd_issuer_if #(.DEPTH(4), .TAG_W(4)) bus ();

    alu_cmd_issuer #(.DEPTH(4), .TAG_W(4)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f);
        case (f)
            4'b0000: return a + b;
            4'b0001: return a - b;
            4'b0011: return (b == 16'd0) ? 16'd0 : a / b;
            default: return 16'd0;
        endcase
    endfunction

    always @(posedge clk) alu_out <= alu_f(bus.ALU_A, bus.ALU_B, bus.ALU_FUN);

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f, input logic [3:0] t);
        bus.CMD_A     = a;
        bus.CMD_B     = b;
        bus.CMD_FUN   = f;
        bus.CMD_TAG   = t;
        bus.CMD_VALID = 1'b1;
    endtask

    task automatic grab(input int c);
        if (bus.RES_VALID === 1'b1) begin
            res_tag_q.push_back(int'(bus.RES_TAG));
            res_out_q.push_back(int'(alu_out));
            res_cyc_q.push_back(c);
        end
    endtask

    initial begin
        int idx;
        int maxlvl;
        int pulses;
        logic acc;
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        bus.CMD_VALID = 1'b0;
        bus.CMD_A = '0;
        bus.CMD_B = '0;
        bus.CMD_FUN = '0;
        bus.CMD_TAG = '0;
        bus.HALT = 1'b0;
        cyc();
        cyc();
        chk("rst_ready", bus.CMD_READY, 0);
        chk("rst_level", bus.CMD_LEVEL, 0);
        chk("rst_alu_fun", bus.ALU_FUN, 4'hf);
        chk("rst_alu_a", bus.ALU_A, 0);
        chk("rst_res_valid", bus.RES_VALID, 0);
        chk("rst_busy", bus.BUSY, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", bus.CMD_READY, 1);

        // Single op: 7 + 5, tag 3
        drive(16'd7, 16'd5, 4'b0000, 4'd3);
        cyc();
        bus.CMD_VALID = 1'b0;
        chk("single_level", bus.CMD_LEVEL, 1);
        chk("single_e0_res", bus.RES_VALID, 0);
        cyc();
        chk("single_alu_fun", bus.ALU_FUN, 4'b0000);
        chk("single_alu_a", bus.ALU_A, 7);
        chk("single_alu_b", bus.ALU_B, 5);
        chk("single_e1_res", bus.RES_VALID, 0);
        chk("single_busy", bus.BUSY, 1);
        cyc();
        chk("single_res_valid", bus.RES_VALID, 1);
        chk("single_res_tag", bus.RES_TAG, 3);
        chk("single_alu_out", alu_out, 12);
        chk("single_divz", bus.RES_DIVZ, 0);
        chk("single_fun_nop", bus.ALU_FUN, 4'hf);
        cyc();
        chk("single_pulse_end", bus.RES_VALID, 0);
        chk("single_idle_busy", bus.BUSY, 0);

        // Fill under HALT, then drain
        bus.HALT = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive(16'(i * 10), 16'(i), 4'b0000, 4'(i));
            cyc();
        end
        drive(16'd50, 16'd5, 4'b0000, 4'd5);
        chk("full_ready", bus.CMD_READY, 0);
        chk("full_level", bus.CMD_LEVEL, 4);
        cyc();
        chk("full_hold_level", bus.CMD_LEVEL, 4);
        chk("full_hold_res", bus.RES_VALID, 0);
        bus.HALT = 1'b0;
        res_tag_q.delete(); res_out_q.delete(); res_cyc_q.delete();
        for (int c = 0; c < 12; c++) begin
            acc = bus.CMD_VALID && bus.CMD_READY;
            cyc();
            if (acc) bus.CMD_VALID = 1'b0;
            grab(c);
        end
        chk("fill_count", res_tag_q.size(), 5);
        for (int k = 0; k < 5 && k < res_tag_q.size(); k++) begin
            chk("fill_tag", res_tag_q[k], k + 1);
            chk("fill_out", res_out_q[k], 11 * (k + 1));
        end
        if (res_cyc_q.size() == 5) chk("fill_no_gaps", res_cyc_q[4] - res_cyc_q[0], 4);

        // Divide by zero, then a legal divide
        drive(16'd100, 16'd0, 4'b0011, 4'd9);
        cyc();
        bus.CMD_VALID = 1'b0;
        cyc();
        chk("dz_alu_fun", bus.ALU_FUN, 4'hf);
        chk("dz_alu_a", bus.ALU_A, 0);
        chk("dz_alu_b", bus.ALU_B, 0);
        cyc();
        chk("dz_res_valid", bus.RES_VALID, 1);
        chk("dz_res_divz", bus.RES_DIVZ, 1);
        chk("dz_res_tag", bus.RES_TAG, 9);
        chk("dz_alu_out", alu_out, 0);
        drive(16'd100, 16'd4, 4'b0011, 4'd10);
        cyc();
        bus.CMD_VALID = 1'b0;
        cyc();
        chk("div_alu_fun", bus.ALU_FUN, 4'b0011);
        cyc();
        chk("div_res_valid", bus.RES_VALID, 1);
        chk("div_res_divz", bus.RES_DIVZ, 0);
        chk("div_res_tag", bus.RES_TAG, 10);
        chk("div_alu_out", alu_out, 25);
        cyc();

        // Streaming 10 ops back to back
        res_tag_q.delete(); res_out_q.delete(); res_cyc_q.delete();
        maxlvl = 0;
        for (int c = 0; c < 14; c++) begin
            if (c < 10) drive(16'(c), 16'd1, 4'b0000, 4'(c));
            else bus.CMD_VALID = 1'b0;
            cyc();
            if (int'(bus.CMD_LEVEL) > maxlvl) maxlvl = int'(bus.CMD_LEVEL);
            grab(c);
        end
        chk("stream_max_level", maxlvl, 1);
        chk("stream_count", res_tag_q.size(), 10);
        for (int k = 0; k < 10 && k < res_tag_q.size(); k++) begin
            chk("stream_tag", res_tag_q[k], k);
            chk("stream_out", res_out_q[k], k + 1);
        end
        if (res_cyc_q.size() == 10) chk("stream_consecutive", res_cyc_q[9] - res_cyc_q[0], 9);

        // HALT for 3 cycles in the middle of a burst
        res_tag_q.delete(); res_out_q.delete(); res_cyc_q.delete();
        idx = 0;
        for (int c = 0; c < 30; c++) begin
            if (idx < 8) drive(16'(idx * 3), 16'(idx), 4'b0000, 4'(idx));
            else bus.CMD_VALID = 1'b0;
            bus.HALT = (c >= 3 && c < 6);
            acc = bus.CMD_VALID && bus.CMD_READY;
            cyc();
            if (acc) idx++;
            if (c == 3) chk("halt_stops_issue", bus.ALU_FUN, 4'hf);
            grab(c);
        end
        bus.CMD_VALID = 1'b0;
        bus.HALT = 1'b0;
        chk("halt_all_accepted", idx, 8);
        chk("halt_count", res_tag_q.size(), 8);
        for (int k = 0; k < 8 && k < res_tag_q.size(); k++) begin
            chk("halt_tag", res_tag_q[k], k);
            chk("halt_out", res_out_q[k], 4 * k);
        end

        // Reset with 3 queued and 1 in flight
        bus.HALT = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(16'd1, 16'd1, 4'b0000, 4'(i + 4));
            cyc();
        end
        bus.CMD_VALID = 1'b0;
        bus.HALT = 1'b0;
        cyc();
        cyc();
        chk("mid_level", bus.CMD_LEVEL, 3);
        chk("mid_alu_fun", bus.ALU_FUN, 4'b0000);
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", bus.CMD_READY, 0);
        cyc();
        rst = 1'b0;
        chk("mid_rst_res_valid", bus.RES_VALID, 0);
        chk("mid_rst_level", bus.CMD_LEVEL, 0);
        chk("mid_rst_alu_fun", bus.ALU_FUN, 4'hf);
        chk("mid_rst_busy", bus.BUSY, 0);
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            cyc();
            if (bus.RES_VALID === 1'b1) pulses++;
        end
        chk("mid_rst_no_pulses", pulses, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
